// File: rtl/definitions_pkg.sv
// rtl/definitions_pkg.sv - shared constants and reader state type for the kernel window loader
// Kernel ceiling, default line width and the reader FSM encoding.
package definitions_pkg;

   localparam int KWL_MAX_KERNEL = 7;
   localparam int IMAGE_WIDTH    = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      RELEASE
   } kwl_rd_state_t;

endpackage

// File: rtl/kwl_line_mem.sv
// rtl/kwl_line_mem.sv - one image line: single write port, KERNEL consecutive pixels read per cycle
// Read data is registered, so a window column address yields its pixels one cycle later.
module kwl_line_mem #(
   parameter int ITEM_SIZE   = 8,
   parameter int IMAGE_WIDTH = 8,
   parameter int KERNEL      = 3,
   parameter int AW          = 3
) (
   input  logic                        clk,
   input  logic                        wr_en,
   input  logic [AW-1:0]               wr_addr,
   input  logic [ITEM_SIZE-1:0]        wr_data,
   input  logic [AW-1:0]               rd_addr,
   output logic [KERNEL*ITEM_SIZE-1:0] rd_data
);

   logic [ITEM_SIZE-1:0]        mem_q [IMAGE_WIDTH];
   logic [KERNEL*ITEM_SIZE-1:0] rd_data_d;
   logic [KERNEL*ITEM_SIZE-1:0] rd_data_q;

   always_comb begin
      rd_data_d = '0;
      for (int c = 0; c < KERNEL; c++) begin
         rd_data_d[c*ITEM_SIZE +: ITEM_SIZE] = mem_q[rd_addr + AW'(c)];
      end
   end

   // Storage is deliberately left out of reset; only pointers need a defined value.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/kernel_window_loader.sv
// rtl/kernel_window_loader.sv - streams KERNEL x KERNEL windows out of a ring of KERNEL+1 line memories
// Define KWL_STATS_EN to add the window_count / stall_count statistics outputs.
module kernel_window_loader #(
   parameter int ITEM_SIZE   = 8,
   parameter int IMAGE_WIDTH = definitions_pkg::IMAGE_WIDTH,
   parameter int KERNEL      = 3
) (
   input  logic                               clk,
   input  logic                               rstN,
   input  logic                               frame_restart,
   input  logic [ITEM_SIZE-1:0]               pixel_in,
   input  logic                               pixel_in_valid,
   output logic                               pixel_in_ready,
   output logic [KERNEL*KERNEL*ITEM_SIZE-1:0] win_data,
   output logic                               win_valid,
   input  logic                               win_ready,
   output logic                               win_eol
`ifdef KWL_STATS_EN
   ,
   output logic [31:0]                        window_count,
   output logic [31:0]                        stall_count
`endif
);

   import definitions_pkg::*;

   localparam int NUM_LINES = KERNEL + 1;
   localparam int AW        = $clog2(IMAGE_WIDTH);
   localparam int LW        = $clog2(NUM_LINES);
   localparam int SW        = LW + 1;
   localparam int FW        = $clog2(NUM_LINES + 1);
   localparam int RW        = KERNEL * ITEM_SIZE;
   localparam int WW        = KERNEL * RW;
   localparam logic [AW-1:0] LAST_WR_COL = AW'(IMAGE_WIDTH - 1);
   localparam logic [AW-1:0] LAST_RD_COL = AW'(IMAGE_WIDTH - KERNEL);
   localparam logic [LW-1:0] LAST_LINE   = LW'(NUM_LINES - 1);
   localparam logic [FW-1:0] FULL        = FW'(NUM_LINES);
   localparam logic [FW-1:0] NEED        = FW'(KERNEL);

   kwl_rd_state_t state_q, state_d;
   logic [AW-1:0] wr_col_q, wr_col_d, rd_col_q, rd_col_d;
   logic [LW-1:0] wr_line_q, wr_line_d, rd_base_q, rd_base_d, pend_base_q, pend_base_d;
   logic [FW-1:0] lines_full_q, lines_full_d;
   logic          ready_en_q, ready_en_d;
   logic          pend_valid_q, pend_valid_d, pend_eol_q, pend_eol_d;
   logic          win_valid_q, win_valid_d, win_eol_q, win_eol_d;
   logic          skid_valid_q, skid_valid_d, skid_eol_q, skid_eol_d;
   logic [WW-1:0] win_data_q, win_data_d, skid_data_q, skid_data_d;
`ifdef KWL_STATS_EN
   logic [31:0]   window_count_q, window_count_d, stall_count_q, stall_count_d;
`endif

   logic          accept, line_done, release_now, pop, issue;
   logic [1:0]    occupancy;
   logic [RW-1:0] line_rd [NUM_LINES];
   logic [WW-1:0] pend_win;
   logic [SW-1:0] sel;

   assign pixel_in_ready = ready_en_q & (lines_full_q < FULL);
   assign accept         = pixel_in_valid & pixel_in_ready;
   assign line_done      = accept & (wr_col_q == LAST_WR_COL);
   assign release_now    = (state_q == RELEASE);
   assign pop            = win_valid_q & win_ready;
   // A read is only launched when the output and skid slots can absorb it on landing.
   assign occupancy      = 2'(pend_valid_q) + 2'(win_valid_q) + 2'(skid_valid_q) - 2'(pop);
   assign issue          = (state_q == RUN) & (occupancy <= 2'd1);

   for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
      kwl_line_mem #(
         .ITEM_SIZE  (ITEM_SIZE),
         .IMAGE_WIDTH(IMAGE_WIDTH),
         .KERNEL     (KERNEL),
         .AW         (AW)
      ) u_line_mem (
         .clk    (clk),
         .wr_en  (accept & ~frame_restart & (wr_line_q == LW'(l))),
         .wr_addr(wr_col_q),
         .wr_data(pixel_in),
         .rd_addr(rd_col_q),
         .rd_data(line_rd[l])
      );
   end

   always_comb begin
      pend_win = '0;
      sel      = '0;
      for (int r = 0; r < KERNEL; r++) begin
         sel = {1'b0, pend_base_q} + SW'(r);
         if (sel >= SW'(NUM_LINES)) begin
            sel = sel - SW'(NUM_LINES);
         end
         pend_win[r*RW +: RW] = line_rd[sel[LW-1:0]];
      end
   end

   always_comb begin
      state_d      = state_q;
      wr_col_d     = wr_col_q;
      wr_line_d    = wr_line_q;
      rd_col_d     = rd_col_q;
      rd_base_d    = rd_base_q;
      ready_en_d   = 1'b1;
      pend_valid_d = issue;
      pend_eol_d   = pend_eol_q;
      pend_base_d  = pend_base_q;
      win_valid_d  = win_valid_q;
      win_eol_d    = win_eol_q;
      win_data_d   = win_data_q;
      skid_valid_d = skid_valid_q;
      skid_eol_d   = skid_eol_q;
      skid_data_d  = skid_data_q;
`ifdef KWL_STATS_EN
      window_count_d = window_count_q;
      stall_count_d  = stall_count_q;
`endif

      if (accept) begin
         if (wr_col_q == LAST_WR_COL) begin
            wr_col_d  = '0;
            wr_line_d = (wr_line_q == LAST_LINE) ? '0 : wr_line_q + 1'b1;
         end else begin
            wr_col_d = wr_col_q + 1'b1;
         end
      end
      lines_full_d = lines_full_q + FW'(line_done) - FW'(release_now);

      case (state_q)
         IDLE: begin
            rd_col_d = '0;
            if (lines_full_q >= NEED) state_d = RUN;
         end
         RUN: begin
            if (issue) begin
               if (rd_col_q == LAST_RD_COL) state_d = RELEASE;
               else rd_col_d = rd_col_q + 1'b1;
            end
         end
         RELEASE: begin
            rd_col_d  = '0;
            rd_base_d = (rd_base_q == LAST_LINE) ? '0 : rd_base_q + 1'b1;
            state_d   = (lines_full_d >= NEED) ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         pend_eol_d  = (rd_col_q == LAST_RD_COL);
         pend_base_d = rd_base_q;
      end

      // Window order is output slot, then skid slot, then the read in flight.
      if (!win_valid_q || pop) begin
         if (skid_valid_q) begin
            win_valid_d  = 1'b1;
            win_data_d   = skid_data_q;
            win_eol_d    = skid_eol_q;
            skid_valid_d = pend_valid_q;
            skid_data_d  = pend_win;
            skid_eol_d   = pend_eol_q;
         end else begin
            win_valid_d = pend_valid_q;
            if (pend_valid_q) begin
               win_data_d = pend_win;
               win_eol_d  = pend_eol_q;
            end
         end
      end else if (pend_valid_q) begin
         skid_valid_d = 1'b1;
         skid_data_d  = pend_win;
         skid_eol_d   = pend_eol_q;
      end

`ifdef KWL_STATS_EN
      if (pop && (window_count_q != '1)) window_count_d = window_count_q + 32'd1;
      if (win_valid_q && !win_ready && (stall_count_q != '1)) stall_count_d = stall_count_q + 32'd1;
`endif

      if (frame_restart) begin
         state_d      = IDLE;
         wr_col_d     = '0;
         wr_line_d    = '0;
         rd_col_d     = '0;
         rd_base_d    = '0;
         lines_full_d = '0;
         pend_valid_d = 1'b0;
         pend_eol_d   = 1'b0;
         pend_base_d  = '0;
         win_valid_d  = 1'b0;
         win_eol_d    = 1'b0;
         win_data_d   = '0;
         skid_valid_d = 1'b0;
         skid_eol_d   = 1'b0;
         skid_data_d  = '0;
`ifdef KWL_STATS_EN
         window_count_d = '0;
         stall_count_d  = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q      <= IDLE;
         wr_col_q     <= '0;
         wr_line_q    <= '0;
         rd_col_q     <= '0;
         rd_base_q    <= '0;
         lines_full_q <= '0;
         ready_en_q   <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_eol_q   <= 1'b0;
         pend_base_q  <= '0;
         win_valid_q  <= 1'b0;
         win_eol_q    <= 1'b0;
         win_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_eol_q   <= 1'b0;
         skid_data_q  <= '0;
`ifdef KWL_STATS_EN
         window_count_q <= '0;
         stall_count_q  <= '0;
`endif
      end else begin
         state_q      <= state_d;
         wr_col_q     <= wr_col_d;
         wr_line_q    <= wr_line_d;
         rd_col_q     <= rd_col_d;
         rd_base_q    <= rd_base_d;
         lines_full_q <= lines_full_d;
         ready_en_q   <= ready_en_d;
         pend_valid_q <= pend_valid_d;
         pend_eol_q   <= pend_eol_d;
         pend_base_q  <= pend_base_d;
         win_valid_q  <= win_valid_d;
         win_eol_q    <= win_eol_d;
         win_data_q   <= win_data_d;
         skid_valid_q <= skid_valid_d;
         skid_eol_q   <= skid_eol_d;
         skid_data_q  <= skid_data_d;
`ifdef KWL_STATS_EN
         window_count_q <= window_count_d;
         stall_count_q  <= stall_count_d;
`endif
      end
   end

   assign win_valid = win_valid_q;
   assign win_eol   = win_eol_q;
   assign win_data  = win_data_q;
`ifdef KWL_STATS_EN
   assign window_count = window_count_q;
   assign stall_count  = stall_count_q;
`endif

endmodule

// File: tb/tb_kernel_window_loader.sv
// tb/tb_kernel_window_loader.sv - self-checking bench for kernel_window_loader (8-wide lines, 3x3 kernel)
// Expected windows come from a raster model: pixel(row,col) = row*16+col.
module tb_kernel_window_loader;

   localparam int IS = 8;
   localparam int IW = 8;
   localparam int K  = 3;
   localparam int WW = K * K * IS;
   localparam logic [WW-1:0] FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;

   logic          clk = 1'b0;
   logic          rstN = 1'b1;
   logic          frame_restart = 1'b0;
   logic [IS-1:0] pixel_in = '0;
   logic          pixel_in_valid = 1'b0;
   logic          pixel_in_ready;
   logic [WW-1:0] win_data;
   logic          win_valid;
   logic          win_ready = 1'b0;
   logic          win_eol;
`ifdef KWL_STATS_EN
   logic [31:0]   window_count;
   logic [31:0]   stall_count;
`endif

   kernel_window_loader #(
      .ITEM_SIZE  (IS),
      .IMAGE_WIDTH(IW),
      .KERNEL     (K)
   ) dut (
      .clk           (clk),
      .rstN          (rstN),
      .frame_restart (frame_restart),
      .pixel_in      (pixel_in),
      .pixel_in_valid(pixel_in_valid),
      .pixel_in_ready(pixel_in_ready),
      .win_data      (win_data),
      .win_valid     (win_valid),
      .win_ready     (win_ready),
      .win_eol       (win_eol)
`ifdef KWL_STATS_EN
      ,
      .window_count  (window_count),
      .stall_count   (stall_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WW-1:0] data;
      logic          eol;
   } win_t;

   win_t          exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            rmode = 0;
   bit            check_en = 0;
   bit            stall_prev = 0;
   logic [WW-1:0] prev_data;
   logic          prev_eol;
   int            n_win, n_eol, first_cyc, last_cyc;
   logic [WW-1:0] first_data;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0: win_ready = 1'b1;
            1: win_ready = 1'b0;
            default: win_ready = ~win_ready;
         endcase
      end
   end

   task automatic check_v(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic check_i(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic logic [IS-1:0] pix(input int r, input int c);
      return IS'(r * 16 + c);
   endfunction

   task automatic push_frame(input int rows);
      win_t w;
      for (int r0 = 0; r0 + K <= rows; r0++) begin
         for (int col = 0; col + K <= IW; col++) begin
            w.data = '0;
            for (int r = 0; r < K; r++)
               for (int c = 0; c < K; c++)
                  w.data[(r*K+c)*IS +: IS] = pix(r0 + r, col + c);
            w.eol = (col == IW - K);
            exp_q.push_back(w);
         end
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         if (stall_prev) begin
            checks++;
            if (win_valid !== 1'b1 || win_data !== prev_data || win_eol !== prev_eol) begin
               errors++;
               $display("FAIL hold: valid=%b data=%h eol=%b expected valid=1 data=%h eol=%b",
                        win_valid, win_data, win_eol, prev_data, prev_eol);
            end
         end
         if (win_valid && win_ready) begin
            win_t e;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_window: got %h expected no window", win_data);
            end else begin
               e = exp_q.pop_front();
               if (win_data !== e.data || win_eol !== e.eol) begin
                  errors++;
                  $display("FAIL window: got %h eol=%b expected %h eol=%b", win_data, win_eol, e.data, e.eol);
               end
            end
            n_win++;
            if (win_eol) n_eol++;
            if (n_win == 1) begin
               first_cyc  = cyc;
               first_data = win_data;
            end
            last_cyc = cyc;
         end
         stall_prev = win_valid && !win_ready;
         prev_data  = win_data;
         prev_eol   = win_eol;
      end else begin
         stall_prev = 0;
      end
   end

   task automatic clear_sb();
      exp_q.delete();
      n_win = 0;
      n_eol = 0;
      first_cyc = 0;
      last_cyc = 0;
      first_data = '0;
   endtask

   task automatic do_reset();
      check_en = 0;
      rstN = 1'b0;
      frame_restart = 1'b0;
      pixel_in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      clear_sb();
      rstN = 1'b1;
      @(posedge clk);
      #1;
      check_en = 1;
   endtask

   task automatic send_pixel(input logic [IS-1:0] v, input int max_wait, output bit ok, output int waits);
      pixel_in = v;
      pixel_in_valid = 1'b1;
      ok = 0;
      waits = 0;
      for (int i = 0; i < max_wait; i++) begin
         @(negedge clk);
         if (pixel_in_ready) begin
            ok = 1;
            break;
         end
         waits++;
      end
      if (ok) begin
         @(posedge clk);
         #1;
      end
      pixel_in_valid = 1'b0;
   endtask

   task automatic stream_rows(input int rows, output int total_waits);
      bit ok;
      int w;
      total_waits = 0;
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < IW; c++) begin
            send_pixel(pix(r, c), 50, ok, w);
            if (!ok) begin
               checks++;
               errors++;
               $display("FAIL stream_timeout: pixel r%0d c%0d not accepted, expected acceptance", r, c);
               return;
            end
            total_waits += w;
         end
      end
   endtask

   task automatic wait_drain(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      check_i({name, "_drain_left"}, exp_q.size(), 0);
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic run_basic(input string name);
      int w;
      push_frame(3);
      check_v({name, "_model_first"}, exp_q[0].data, FIRST_WIN);
      check_i({name, "_model_eol6"}, int'(exp_q[5].eol), 1);
      stream_rows(3, w);
      check_i({name, "_input_waits"}, w, 0);
      repeat (3) @(posedge clk);
      #1;
      check_i({name, "_first_latency"}, int'(win_valid), 1);
      wait_drain(name, 200);
      check_i({name, "_windows"}, n_win, 6);
      check_i({name, "_eol_count"}, n_eol, 1);
      check_i({name, "_span"}, last_cyc - first_cyc, 5);
      check_v({name, "_first_data"}, first_data, FIRST_WIN);
   endtask

   initial begin
      int  w, accepted;
      bit  ok;

      // Power-on reset and release
      #1 rstN = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_i("rst_win_valid", int'(win_valid), 0);
      check_i("rst_win_eol", int'(win_eol), 0);
      check_v("rst_win_data", win_data, '0);
      check_i("rst_ready", int'(pixel_in_ready), 0);
      rstN = 1'b1;
      #2;
      check_i("ready_before_edge", int'(pixel_in_ready), 0);
      @(posedge clk);
      #1;
      check_i("ready_after_edge", int'(pixel_in_ready), 1);

      // Three rows, consumer always ready
      rmode = 0;
      do_reset();
      run_basic("basic");

      // Consumer never ready: ring fills and the first window freezes
      rmode = 1;
      do_reset();
      accepted = 0;
      for (int i = 0; i < 40; i++) begin
         send_pixel(pix(i / IW, i % IW), 20, ok, w);
         if (!ok) break;
         accepted++;
      end
      check_i("stall_accepted", accepted, 32);
      check_i("stall_ready", int'(pixel_in_ready), 0);
      check_i("stall_valid", int'(win_valid), 1);
      check_v("stall_data", win_data, FIRST_WIN);
      check_i("stall_no_pops", n_win, 0);
      @(posedge clk);
      #1;
      check_en = 0;
      frame_restart = 1'b1;
      @(posedge clk);
      #1;
      frame_restart = 1'b0;
      check_i("restart_valid", int'(win_valid), 0);
      check_v("restart_data", win_data, '0);
      check_i("restart_ready", int'(pixel_in_ready), 1);

      // Ten rows, consumer toggling
      rmode = 2;
      do_reset();
      push_frame(10);
      check_i("toggle_model_count", exp_q.size(), 48);
      stream_rows(10, w);
      wait_drain("toggle", 2000);
      check_i("toggle_windows", n_win, 48);

      // Five rows: a line completes in the same cycle as a release
      rmode = 0;
      do_reset();
      push_frame(5);
      stream_rows(5, w);
      check_i("coincide_input_waits", w, 0);
      wait_drain("coincide", 500);
      check_i("coincide_windows", n_win, 18);

      // frame_restart alongside pixel 13, then a clean frame
      rmode = 0;
      do_reset();
      for (int i = 0; i < 13; i++) send_pixel(pix(i / IW, i % IW), 20, ok, w);
      pixel_in = pix(1, 5);
      pixel_in_valid = 1'b1;
      frame_restart = 1'b1;
      @(posedge clk);
      #1;
      frame_restart = 1'b0;
      pixel_in_valid = 1'b0;
      check_i("fr13_valid", int'(win_valid), 0);
      check_i("fr13_ready", int'(pixel_in_ready), 1);
      clear_sb();
      run_basic("after_restart");

      // Half-cycle reset pulse mid-row with a window pending
      rmode = 1;
      do_reset();
      stream_rows(3, w);
      for (int c = 0; c < 3; c++) send_pixel(pix(3, c), 20, ok, w);
      repeat (3) @(posedge clk);
      #1;
      check_i("pulse_pre_valid", int'(win_valid), 1);
      check_en = 0;
      rmode = 0;
      @(posedge clk);
      #2;
      rstN = 1'b0;
      #1;
      check_i("pulse_valid", int'(win_valid), 0);
      check_i("pulse_eol", int'(win_eol), 0);
      check_v("pulse_data", win_data, '0);
      check_i("pulse_ready", int'(pixel_in_ready), 0);
      #4;
      rstN = 1'b1;
      @(posedge clk);
      #1;
      check_i("pulse_ready_rise", int'(pixel_in_ready), 1);
      clear_sb();
      check_en = 1;
      run_basic("after_pulse");
`ifdef KWL_STATS_EN
      check_i("stats_window_count", int'(window_count), 6);
      check_i("stats_stall_count", int'(stall_count), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
